draw_sequencer: RTL and testbench

DRAW_SEQUENCER -- requirements
Module: draw_sequencer

---
 rtl/draw_sequencer_pkg.sv | 23 ++
 rtl/draw_lfsr.sv | 25 ++
 rtl/draw_sequencer.sv | 153 +++++++++++++++
 tb/tb_draw_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_sequencer_pkg.sv
// Shared types and constants for the draw sequencer and the payout block.
package draw_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } draw_state_t;

    typedef logic [3:0] digit_t;

    localparam int     NUM_SLOTS       = 10;
    localparam digit_t MAX_DIGIT_VALUE = 4'd9;

    // A request of 0 digits, or more than the slot count, means "fill every slot".
    function automatic logic [3:0] eff_count(input logic [3:0] n, input logic [3:0] max_cnt);
        if (n == 4'd0 || n > max_cnt) begin
            return max_cnt;
        end
        return n;
    endfunction

endpackage

// File: rtl/draw_lfsr.sv
// 16-bit Fibonacci LFSR with seed load; a zero seed is replaced by the default
// seed so the register can never lock up in the all-zero state.
module draw_lfsr #(
    parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    // Load has priority over step; the register holds when neither is asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= DEFAULT_SEED;
        end else if (load) begin
            value <= (seed == 16'h0000) ? DEFAULT_SEED : seed;
        end else if (step) begin
            value <= {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
        end
    end

endmodule

// File: rtl/draw_sequencer.sv
// Draws up to MAX_DIGITS decimal digits from an LFSR by rejection sampling
// of the low nibble, and presents them as a slot array plus enable mask.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; seed loads honoured here only
// DRAW    | one LFSR step per cycle, accepting nibbles 0..9 into slots
// DONE    | one-cycle completion pulse, result valid, counter bumped
module draw_sequencer
    import draw_sequencer_pkg::*;
#(
    parameter logic [15:0] DEFAULT_SEED = 16'hACE1,
    parameter int          MAX_DIGITS   = NUM_SLOTS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [3:0]            num_digits,
    input  logic                  seed_load,
    input  logic [15:0]           seed,
    output logic                  busy,
    output digit_t                draw [MAX_DIGITS-1:0],
    output logic [MAX_DIGITS-1:0] en,
    output logic                  draw_valid,
    output logic                  done,
    output logic [7:0]            draw_count
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

    draw_state_t state_q;
    draw_state_t state_d;
    logic [3:0]  cnt_q;
    logic [3:0]  idx_q;
    logic [15:0] lfsr_value;
    logic        lfsr_load;
    logic        lfsr_step;
    digit_t      candidate;
    logic        accept;
    logic        last_slot;
    logic        start_ok;
    logic        lfsr_upper_unused;

    // Seed loading happens on the same edge that samples start, so a combined
    // seed_load+start draws from the freshly loaded seed.
    assign lfsr_load = seed_load && (state_q == ST_IDLE);
    assign lfsr_step = (state_q == ST_DRAW);

    draw_lfsr #(
        .DEFAULT_SEED(DEFAULT_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .step (lfsr_step),
        .seed (seed),
        .value(lfsr_value)
    );

    // Upper LFSR bits only feed the shift register itself.
    assign lfsr_upper_unused = ^lfsr_value[15:4];

    assign candidate = lfsr_value[3:0];
    assign accept    = (candidate <= MAX_DIGIT_VALUE);
    assign last_slot = (idx_q == (cnt_q - 4'd1));
    assign start_ok  = start && (state_q == ST_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_DRAW;
            ST_DRAW: if (accept && last_slot) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_DRAW: busy = 1'b1;
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Target count and write index for the current draw.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (start_ok) begin
            cnt_q <= eff_count(num_digits, MAX_CNT);
            idx_q <= '0;
        end else if (state_q == ST_DRAW && accept) begin
            idx_q <= idx_q + 4'd1;
        end
    end

    // Slot array and enable mask; only written in DRAW so they hold while valid.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            for (int k = 0; k < MAX_DIGITS; k++) begin
                draw[k] <= '0;
            end
            en <= '0;
        end else if (state_q == ST_DRAW && accept) begin
            for (int k = 0; k < MAX_DIGITS; k++) begin
                if (idx_q == 4'(k)) begin
                    draw[k] <= candidate;
                    en[k]   <= 1'b1;
                end
            end
        end
    end

    // Result-valid flag: raised on entry to DONE, dropped by the next accepted start.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            draw_valid <= 1'b0;
        end else if (state_q == ST_DRAW && accept && last_slot) begin
            draw_valid <= 1'b1;
        end
    end

    // Completed-draw counter, wrapping at 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            draw_count <= '0;
        end else if (state_q == ST_DONE) begin
            draw_count <= draw_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_draw_sequencer.sv
// Self-checking bench for draw_sequencer: fixed vector table, randomized draws
// against a behavioural model, and hand sequences for busy/reset/wrap cases.
module tb_draw_sequencer;
    import draw_sequencer_pkg::*;

    localparam logic [15:0] DEF = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  num_digits;
    logic        seed_load;
    logic [15:0] seed;
    logic        busy;
    digit_t      draw_o [9:0];
    logic [9:0]  en;
    logic        draw_valid;
    logic        done;
    logic [7:0]  draw_count;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] mlfsr;
    logic [7:0]  exp_count;

    typedef struct {
        logic        do_seed;
        logic [15:0] sd;
        logic [3:0]  n;
        logic [39:0] xd;
        logic [9:0]  xe;
        int          xcyc;
    } vec_t;

    vec_t vecs [6];

    draw_sequencer #(
        .DEFAULT_SEED(DEF),
        .MAX_DIGITS  (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_digits(num_digits),
        .seed_load (seed_load),
        .seed      (seed),
        .busy      (busy),
        .draw      (draw_o),
        .en        (en),
        .draw_valid(draw_valid),
        .done      (done),
        .draw_count(draw_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] pack_draw();
        logic [39:0] p = '0;
        for (int k = 0; k < 10; k++) p[k*4 +: 4] = draw_o[k];
        return p;
    endfunction

    // Reference: step the polynomial, keep nibbles 0..9 until count reached.
    task automatic model(input logic [15:0] s_in, input logic [3:0] n,
                         output logic [39:0] d, output logic [9:0] e,
                         output int cyc, output logic [15:0] s_end);
        logic [15:0] s = s_in;
        int cnt = (n == 0 || n > 10) ? 10 : int'(n);
        int got = 0;
        d = '0; e = '0; cyc = 0;
        while (got < cnt && cyc < 1000) begin
            if (s[3:0] <= 4'd9) begin
                d[got*4 +: 4] = s[3:0];
                e[got] = 1'b1;
                got++;
            end
            s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
            cyc++;
        end
        s_end = s;
    endtask

    task automatic run_draw(input string name, input logic do_seed, input logic [15:0] sd,
                            input logic [3:0] n, input logic [39:0] xd, input logic [9:0] xe,
                            input int xcyc);
        logic [39:0] md;
        logic [9:0]  me;
        int          mc;
        int          cyc;
        logic [39:0] held;
        if (do_seed) mlfsr = (sd == 16'h0) ? DEF : sd;
        model(mlfsr, n, md, me, mc, mlfsr);
        start = 1'b1; seed_load = do_seed; seed = sd; num_digits = n;
        tick();
        start = 1'b0; seed_load = 1'b0;
        cyc = 0;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
        end
        exp_count = exp_count + 8'd1;
        chk({name, " done"}, done, 1);
        chk({name, " latency"}, cyc, xcyc);
        chk({name, " busy"}, busy, 1);
        chk({name, " valid"}, draw_valid, 1);
        chk({name, " draw"}, pack_draw(), xd);
        chk({name, " en"}, en, xe);
        held = pack_draw();
        tick();
        chk({name, " pulse"}, done, 0);
        chk({name, " idle"}, busy, 0);
        chk({name, " hold"}, draw_valid, 1);
        chk({name, " stable"}, pack_draw(), xd);
        chk({name, " count"}, draw_count, exp_count);
        if (held !== xd) chk({name, " drift"}, held, xd);
    endtask

    task automatic quick_draw();
        int cyc = 0;
        start = 1'b1; num_digits = 4'd1;
        tick();
        start = 1'b0;
        while (!done && cyc < 100) begin
            tick();
            cyc++;
        end
        if (!done) chk("quick timeout", done, 1);
        tick();
    endtask

    initial begin
        logic [39:0] xd;
        logic [9:0]  xe;
        int          xc;
        logic [15:0] tmp;
        logic        ds;
        logic [15:0] sd;
        logic [3:0]  n;
        int          dones;
        int          done_at;

        vecs[0] = '{1'b1, 16'h0001, 4'd4,  40'h0000008421, 10'h00F, 4};
        vecs[1] = '{1'b1, 16'h000F, 4'd2,  40'h0000000008, 10'h003, 5};
        vecs[2] = '{1'b1, 16'h0001, 4'd0,  40'h0000008421, 10'h3FF, 10};
        vecs[3] = '{1'b1, 16'h0001, 4'd11, 40'h0000008421, 10'h3FF, 10};
        vecs[4] = '{1'b1, 16'h000A, 4'd1,  40'h0000000004, 10'h001, 2};
        vecs[5] = '{1'b1, 16'h0009, 4'd2,  40'h0000000029, 10'h003, 2};

        rst = 1'b1; start = 1'b0; num_digits = 4'd0; seed_load = 1'b0; seed = 16'h0;
        tick(); tick();
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst valid", draw_valid, 0);
        chk("rst en", en, 0);
        chk("rst draw", pack_draw(), 0);
        chk("rst count", draw_count, 0);
        rst = 1'b0;
        mlfsr = DEF;
        exp_count = 8'd0;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_draw($sformatf("vec%0d", i), vecs[i].do_seed, vecs[i].sd, vecs[i].n,
                     vecs[i].xd, vecs[i].xe, vecs[i].xcyc);
        end

        for (int i = 0; i < 40; i++) begin
            ds = ($urandom_range(0, 2) == 0);
            sd = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
            n  = 4'($urandom_range(0, 15));
            tmp = ds ? ((sd == 16'h0) ? DEF : sd) : mlfsr;
            model(tmp, n, xd, xe, xc, tmp);
            run_draw($sformatf("rnd%0d", i), ds, sd, n, xd, xe, xc);
            repeat ($urandom_range(0, 2)) tick();
        end

        // start and seed_load while busy are ignored
        start = 1'b1; seed_load = 1'b1; seed = 16'h0001; num_digits = 4'd4;
        tick();
        dones = 0; done_at = -1;
        for (int c = 1; c <= 20; c++) begin
            start = (c <= 2); seed_load = (c <= 2); seed = 16'h1234;
            tick();
            if (done) begin
                dones++;
                if (done_at < 0) done_at = c;
            end
        end
        start = 1'b0; seed_load = 1'b0;
        model(16'h0001, 4'd4, xd, xe, xc, mlfsr);
        exp_count = exp_count + 8'd1;
        chk("busy single done", dones, 1);
        chk("busy latency", done_at, 4);
        chk("busy draw", pack_draw(), 40'h0000008421);
        chk("busy count", draw_count, exp_count);

        // reset two cycles into DRAW, dominating start and seed_load
        start = 1'b1; seed_load = 1'b1; seed = 16'h0001; num_digits = 4'd4;
        tick();
        start = 1'b0; seed_load = 1'b0;
        tick(); tick();
        rst = 1'b1; start = 1'b1; seed_load = 1'b1; seed = 16'h5555;
        tick();
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort valid", draw_valid, 0);
        chk("abort en", en, 0);
        chk("abort draw", pack_draw(), 0);
        chk("abort count", draw_count, 0);
        rst = 1'b0; start = 1'b0; seed_load = 1'b0;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done) dones++;
        end
        chk("abort no done", dones, 0);
        mlfsr = DEF;
        exp_count = 8'd0;
        model(DEF, 4'd3, xd, xe, xc, tmp);
        run_draw("post rst", 1'b0, 16'h0, 4'd3, xd, xe, xc);
        model(DEF, 4'd5, xd, xe, xc, tmp);
        run_draw("seed zero", 1'b1, 16'h0000, 4'd5, xd, xe, xc);

        // counter wrap
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 255; i++) quick_draw();
        chk("count 255", draw_count, 8'd255);
        quick_draw();
        chk("count wrap", draw_count, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
